// File: rtl/kds_pkg.sv
// Types and constants shared by the kernel data shifter and its loader.
package kds_pkg;

    typedef enum logic [1:0] {
        KDS_IDLE    = 2'd0,
        KDS_COLLECT = 2'd1,
        KDS_COMMIT  = 2'd2,
        KDS_DONE    = 2'd3
    } kds_state_e;

    localparam int KDS_IO_DATA_WIDTH = 16;
    localparam int KDS_NB_LANES      = 12;
    localparam int KDS_ROW_WORDS     = 3;
    localparam int KDS_ROWS_PER_LANE = 8;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int kds_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kds_loader_if.sv
// Kernel word stream in, shifter row/load-enable bus out, plus loader control strobes.
interface kds_loader_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_LANES      = 12
);

    logic                     start_in;
    logic                     abort_in;
    logic [IO_DATA_WIDTH-1:0] din;
    logic                     din_valid;
    logic                     din_ready;
    logic                     advance_in;
    logic [IO_DATA_WIDTH-1:0] v_1;
    logic [IO_DATA_WIDTH-1:0] v_2;
    logic [IO_DATA_WIDTH-1:0] v_3;
    logic [NB_LANES-1:0]      LE_select;
    logic                     cycle_enable;
    logic                     done;

    modport master (
        output start_in, abort_in, din, din_valid, advance_in,
        input  din_ready, v_1, v_2, v_3, LE_select, cycle_enable, done
    );

    modport slave (
        input  start_in, abort_in, din, din_valid, advance_in,
        output din_ready, v_1, v_2, v_3, LE_select, cycle_enable, done
    );

endinterface

// File: rtl/kds_row_assembler.sv
// Packs three consecutive accepted kernel words into one shifter row.
module kds_row_assembler
    import kds_pkg::*;
#(
    parameter int IO_DATA_WIDTH = KDS_IO_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic [IO_DATA_WIDTH-1:0] din,
    input  logic                     beat,
    input  logic                     clear,
    output logic [IO_DATA_WIDTH-1:0] v_1,
    output logic [IO_DATA_WIDTH-1:0] v_2,
    output logic [IO_DATA_WIDTH-1:0] v_3,
    output logic                     last_word
);

    logic [1:0] wc_q;

    assign last_word = (wc_q == 2'(KDS_ROW_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the word registers are reset because they drive outputs with
    // defined reset values; plain storage arrays would not need this.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wc_q <= 2'd0;
            v_1  <= '0;
            v_2  <= '0;
            v_3  <= '0;
        end else if (clear) begin
            wc_q <= 2'd0;
            v_1  <= '0;
            v_2  <= '0;
            v_3  <= '0;
        end else if (beat) begin
            case (wc_q)
                2'd0:    v_1 <= din;
                2'd1:    v_2 <= din;
                default: v_3 <= din;
            endcase
            wc_q <= last_word ? 2'd0 : wc_q + 2'd1;
        end
    end

endmodule

// File: rtl/kds_loader.sv
// Loader FSM: collects kernel rows and commits them lane by lane into the
// kernel data shifter, then hands the shifter over to the datapath.
module kds_loader
    import kds_pkg::*;
#(
    parameter int IO_DATA_WIDTH = KDS_IO_DATA_WIDTH,
    parameter int NB_LANES      = KDS_NB_LANES,
    parameter int ROWS_PER_LANE = KDS_ROWS_PER_LANE
) (
    input logic         clk,
    input logic         arst_in,
    kds_loader_if.slave bus
);

    localparam int ROW_W  = kds_cnt_width(ROWS_PER_LANE);
    localparam int LANE_W = kds_cnt_width(NB_LANES);

    localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS_PER_LANE - 1);
    localparam logic [LANE_W-1:0]   LANE_LAST = LANE_W'(NB_LANES - 1);
    localparam logic [NB_LANES-1:0] LANE_ONE  = NB_LANES'(1);

    kds_state_e state_q;
    kds_state_e state_d;

    logic [ROW_W-1:0]         row_q;
    logic [LANE_W-1:0]        lane_q;
    logic [NB_LANES-1:0]      le_select_q;
    logic                     cycle_enable_q;
    logic                     done_q;
    logic                     din_ready;
    logic                     beat;
    logic                     last_word;
    logic                     last_row;
    logic                     commit_go;
    logic                     reload;
    logic [IO_DATA_WIDTH-1:0] v_1;
    logic [IO_DATA_WIDTH-1:0] v_2;
    logic [IO_DATA_WIDTH-1:0] v_3;

    assign din_ready = (state_q == KDS_COLLECT);
    // An abort in the same cycle swallows the handshake.
    assign beat      = bus.din_valid && din_ready && !bus.abort_in;
    assign commit_go = beat && last_word;
    assign last_row  = (lane_q == LANE_LAST) && (row_q == ROW_LAST);
    assign reload    = bus.start_in && (state_q == KDS_IDLE || state_q == KDS_DONE);

    kds_row_assembler #(
        .IO_DATA_WIDTH(IO_DATA_WIDTH)
    ) u_row_assembler (
        .clk      (clk),
        .arst_in  (arst_in),
        .din      (bus.din),
        .beat     (beat),
        .clear    (bus.abort_in),
        .v_1      (v_1),
        .v_2      (v_2),
        .v_3      (v_3),
        .last_word(last_word)
    );

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KDS_IDLE:    if (bus.start_in) state_d = KDS_COLLECT;
            KDS_COLLECT: if (commit_go) state_d = KDS_COMMIT;
            KDS_COMMIT:  state_d = last_row ? KDS_DONE : KDS_COLLECT;
            KDS_DONE:    if (bus.start_in) state_d = KDS_COLLECT;
            default:     state_d = KDS_IDLE;
        endcase
        if (bus.abort_in) state_d = KDS_IDLE;
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= KDS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row/lane advance once per commit; the final commit wraps lane to 0
    // so the counter never holds an index past the last lane.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            row_q  <= '0;
            lane_q <= '0;
        end else if (bus.abort_in || state_q == KDS_IDLE || reload) begin
            row_q  <= '0;
            lane_q <= '0;
        end else if (state_q == KDS_COMMIT) begin
            if (row_q == ROW_LAST) begin
                row_q  <= '0;
                lane_q <= last_row ? '0 : lane_q + LANE_W'(1);
            end else begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    // Commit strobes are set one cycle ahead so they line up with COMMIT.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            le_select_q    <= '0;
            cycle_enable_q <= 1'b1;
            done_q         <= 1'b0;
        end else begin
            le_select_q    <= '0;
            cycle_enable_q <= 1'b1;
            if (commit_go) begin
                le_select_q    <= LANE_ONE << lane_q;
                cycle_enable_q <= 1'b0;
            end else if (state_q == KDS_DONE && state_d == KDS_DONE) begin
                cycle_enable_q <= !bus.advance_in;
            end
            done_q <= (state_d == KDS_DONE);
        end
    end

    assign bus.din_ready    = din_ready;
    assign bus.v_1          = v_1;
    assign bus.v_2          = v_2;
    assign bus.v_3          = v_3;
    assign bus.LE_select    = le_select_q;
    assign bus.cycle_enable = cycle_enable_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_kds_loader.sv
// Scoreboard bench for kds_loader: expected commits are queued as rows are
// driven and matched against LE_select pulses; a shifter model tracks lanes.
module tb_kds_loader;

    localparam int W    = 16;
    localparam int NL   = kds_pkg::KDS_NB_LANES;
    localparam int RPL  = kds_pkg::KDS_ROWS_PER_LANE;
    localparam int ROWS = NL * RPL;

    typedef struct packed {
        logic [3:0]  lane;
        logic [2:0]  row;
        logic [47:0] data;
    } commit_t;

    logic clk = 1'b0;
    logic arst_in;

    kds_loader_if #(.IO_DATA_WIDTH(W), .NB_LANES(NL)) bus ();

    kds_loader #(
        .IO_DATA_WIDTH(W),
        .NB_LANES     (NL),
        .ROWS_PER_LANE(RPL)
    ) dut (
        .clk    (clk),
        .arst_in(arst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_commits = 0;
    int          row_idx   = 0;
    logic [3:0]  load_id   = 4'd0;
    commit_t     sb_q[$];
    logic [47:0] exp_rows [NL][RPL];
    logic [47:0] shf      [NL][RPL];
    commit_t     mon_e;
    logic [NL-1:0] mon_le;
    logic [47:0] mon_in;

    // Commit monitor and shifter model: every lane shifts when cycle_enable
    // is low; the selected lane takes the new row, the others recirculate.
    always @(negedge clk) begin
        if (arst_in === 1'b0) begin
            if (bus.cycle_enable === 1'b0) begin
                for (int l = 0; l < NL; l++) begin
                    mon_in = bus.LE_select[l] ? {bus.v_1, bus.v_2, bus.v_3} : shf[l][RPL-1];
                    for (int r = RPL - 1; r > 0; r--) shf[l][r] = shf[l][r-1];
                    shf[l][0] = mon_in;
                end
            end
            if (bus.LE_select !== '0) begin
                n_commits++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL commit_unexpected: got LE_select=%h expected no commit", bus.LE_select);
                end else begin
                    mon_e  = sb_q.pop_front();
                    mon_le = 12'h001 << mon_e.lane;
                    if ({bus.LE_select, bus.v_1, bus.v_2, bus.v_3, bus.cycle_enable, bus.din_ready}
                        !== {mon_le, mon_e.data, 1'b0, 1'b0})
                        $display("FAIL commit_lane%0d_row%0d: got LE=%h v=%h ce=%b rdy=%b expected LE=%h v=%h ce=0 rdy=0",
                                 mon_e.lane, mon_e.row, bus.LE_select, {bus.v_1, bus.v_2, bus.v_3},
                                 bus.cycle_enable, bus.din_ready, mon_le, mon_e.data);
                    else
                        n_pass++;
                end
            end else if (bus.cycle_enable === 1'b0 && bus.done !== 1'b1) begin
                n_checks++;
                $display("FAIL spurious_shift: got cycle_enable=0 expected 1 (LE_select=0, not done)");
            end
        end
    end

    function automatic logic [15:0] word_of(input int ri, input int k, input logic [3:0] id);
        return {4'(ri / RPL), 4'(ri % RPL), 4'(k), id};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [47:0] d);
        commit_t e;
        e.lane = 4'(row_idx / RPL);
        e.row  = 3'(row_idx % RPL);
        e.data = d;
        sb_q.push_back(e);
        exp_rows[row_idx / RPL][row_idx % RPL] = d;
        row_idx++;
    endtask

    task automatic do_start();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        row_idx = 0;
        load_id = load_id + 4'd1;
        n_checks++;
        if (bus.din_ready !== 1'b1) $display("FAIL start_latency: got din_ready=%b expected 1", bus.din_ready);
        else n_pass++;
    endtask

    // Holds din_valid until the word is taken; returns just after that edge.
    task automatic send_word(input logic [15:0] w);
        bit ok;
        ok = 1'b0;
        bus.din       = w;
        bus.din_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (bus.din_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL handshake_timeout: got din_ready=%b expected 1 within 64 cycles", bus.din_ready);
        end
    endtask

    task automatic send_row(input int max_gap);
        logic [47:0] d;
        logic [15:0] w;
        int          gap;
        d = '0;
        for (int k = 0; k < 3; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) tick();
            w = word_of(row_idx, k, load_id);
            d = {d[31:0], w};
            send_word(w);
        end
        push_expected(d);
    endtask

    task automatic drain(input string tag);
        repeat (2) tick();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL %s_drain: got %0d pending commits expected 0", tag, sb_q.size());
        else n_pass++;
    endtask

    task automatic abort_cleanup();
        bus.abort_in = 1'b1;
        tick();
        bus.abort_in = 1'b0;
        sb_q.delete();
        n_checks++;
        if ({bus.din_ready, bus.done} !== 2'b00)
            $display("FAIL abort_idle: got rdy/done=%b expected 00", {bus.din_ready, bus.done});
        else n_pass++;
    endtask

    task automatic test_reset();
        arst_in        = 1'b1;
        bus.start_in   = 1'b0;
        bus.abort_in   = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.advance_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, bus.v_1, bus.v_2, bus.v_3}
            !== {1'b0, 12'h000, 1'b1, 1'b0, 48'h0})
            $display("FAIL reset_values: got rdy=%b LE=%h ce=%b done=%b v=%h expected 0/000/1/0/0",
                     bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, {bus.v_1, bus.v_2, bus.v_3});
        else n_pass++;
        @(negedge clk);
        arst_in = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.din_ready !== 1'b0) $display("FAIL idle_not_ready: got din_ready=%b expected 0", bus.din_ready);
        else n_pass++;

        do_start();
        send_word(16'hBEEF);
        n_checks++;
        if (bus.v_1 !== 16'hBEEF) $display("FAIL word0_to_v1: got v_1=%h expected beef", bus.v_1);
        else n_pass++;
        #3 arst_in = 1'b1;
        #1;
        n_checks++;
        if ({bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, bus.v_1}
            !== {1'b0, 12'h000, 1'b1, 1'b0, 16'h0})
            $display("FAIL async_reset: got rdy=%b LE=%h ce=%b done=%b v_1=%h expected 0/000/1/0/0000",
                     bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, bus.v_1);
        else n_pass++;
        @(negedge clk);
        arst_in = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.din_ready !== 1'b0) $display("FAIL reset_back_idle: got din_ready=%b expected 0", bus.din_ready);
        else n_pass++;
    endtask

    task automatic test_single_row();
        do_start();
        send_word(16'h0011);
        send_word(16'h0022);
        send_word(16'h0033);
        push_expected(48'h0011_0022_0033);
        n_checks++;
        if ({bus.LE_select, bus.cycle_enable, bus.din_ready, bus.v_1, bus.v_2, bus.v_3}
            !== {12'h001, 1'b0, 1'b0, 48'h0011_0022_0033})
            $display("FAIL single_row_commit: got LE=%h ce=%b rdy=%b v=%h expected 001/0/0/001100220033",
                     bus.LE_select, bus.cycle_enable, bus.din_ready, {bus.v_1, bus.v_2, bus.v_3});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.LE_select, bus.cycle_enable, bus.din_ready} !== {12'h000, 1'b1, 1'b1})
            $display("FAIL single_row_after: got LE=%h ce=%b rdy=%b expected 000/1/1",
                     bus.LE_select, bus.cycle_enable, bus.din_ready);
        else n_pass++;
        drain("single_row");
        abort_cleanup();
    endtask

    task automatic test_ignored_inputs();
        int c0;
        logic [47:0] d;
        do_start();
        c0 = n_commits;
        d = {word_of(0, 0, load_id), word_of(0, 1, load_id), word_of(0, 2, load_id)};
        send_word(d[47:32]);
        bus.start_in   = 1'b1;
        bus.advance_in = 1'b1;
        tick();
        bus.start_in   = 1'b0;
        bus.advance_in = 1'b0;
        n_checks++;
        if ({bus.din_ready, bus.cycle_enable, bus.LE_select} !== {1'b1, 1'b1, 12'h000})
            $display("FAIL ignored_in_collect: got rdy=%b ce=%b LE=%h expected 1/1/000",
                     bus.din_ready, bus.cycle_enable, bus.LE_select);
        else n_pass++;
        send_word(d[31:16]);
        send_word(d[15:0]);
        push_expected(d);
        send_row(1);
        drain("ignored");
        n_checks++;
        if (n_commits - c0 != 2) $display("FAIL ignored_commit_count: got %0d expected 2", n_commits - c0);
        else n_pass++;
        abort_cleanup();
    endtask

    task automatic test_abort();
        int c0;
        do_start();
        c0 = n_commits;
        repeat (5 * RPL + 3) send_row(1);
        send_word(word_of(row_idx, 0, load_id));
        bus.din       = word_of(row_idx, 1, load_id);
        bus.din_valid = 1'b1;
        bus.abort_in  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.din_ready !== 1'b1) $display("FAIL abort_setup: got din_ready=%b expected 1", bus.din_ready);
        else n_pass++;
        tick();
        bus.din_valid = 1'b0;
        bus.abort_in  = 1'b0;
        n_checks++;
        if ({bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, bus.v_1, bus.v_2, bus.v_3}
            !== {1'b0, 12'h000, 1'b1, 1'b0, 48'h0})
            $display("FAIL abort_outputs: got rdy=%b LE=%h ce=%b done=%b v=%h expected 0/000/1/0/0",
                     bus.din_ready, bus.LE_select, bus.cycle_enable, bus.done, {bus.v_1, bus.v_2, bus.v_3});
        else n_pass++;
        drain("abort");
        n_checks++;
        if (n_commits - c0 != 5 * RPL + 3)
            $display("FAIL abort_commit_count: got %0d expected %0d", n_commits - c0, 5 * RPL + 3);
        else n_pass++;
        n_checks++;
        if (bus.din_ready !== 1'b0) $display("FAIL abort_stays_idle: got din_ready=%b expected 0", bus.din_ready);
        else n_pass++;
        do_start();
        send_row(0);
        drain("abort_restart");
        abort_cleanup();
    endtask

    task automatic test_full_load();
        int c0;
        logic [RPL*48-1:0] got_l, exp_l;
        do_start();
        c0 = n_commits;
        repeat (ROWS) send_row(2);
        n_checks++;
        if ({bus.done, bus.LE_select} !== {1'b0, 12'h800})
            $display("FAIL last_commit: got done=%b LE=%h expected 0/800", bus.done, bus.LE_select);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.done, bus.din_ready, bus.LE_select, bus.cycle_enable} !== {1'b1, 1'b0, 12'h000, 1'b1})
            $display("FAIL done_rise: got done=%b rdy=%b LE=%h ce=%b expected 1/0/000/1",
                     bus.done, bus.din_ready, bus.LE_select, bus.cycle_enable);
        else n_pass++;
        drain("full_load");
        n_checks++;
        if (n_commits - c0 != ROWS) $display("FAIL full_commit_count: got %0d expected %0d", n_commits - c0, ROWS);
        else n_pass++;
        for (int l = 0; l < NL; l++) begin
            for (int r = 0; r < RPL; r++) begin
                got_l[r*48 +: 48] = shf[l][RPL-1-r];
                exp_l[r*48 +: 48] = exp_rows[l][r];
            end
            n_checks++;
            if (got_l !== exp_l) $display("FAIL lane%0d_order: got %h expected %h", l, got_l, exp_l);
            else n_pass++;
        end
        repeat (4) tick();
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL done_hold: got done=%b expected 1", bus.done);
        else n_pass++;
    endtask

    task automatic test_done();
        logic [3:0] pat;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            bus.advance_in = pat[k];
            tick();
            n_checks++;
            if (bus.cycle_enable !== !pat[k])
                $display("FAIL advance_%0d: got cycle_enable=%b expected %b", k, bus.cycle_enable, !pat[k]);
            else n_pass++;
        end
        bus.advance_in = 1'b0;
        bus.start_in   = 1'b1;
        tick();
        bus.start_in = 1'b0;
        row_idx = 0;
        load_id = load_id + 4'd1;
        n_checks++;
        if ({bus.done, bus.din_ready, bus.cycle_enable} !== 3'b011)
            $display("FAIL done_restart: got done=%b rdy=%b ce=%b expected 0/1/1",
                     bus.done, bus.din_ready, bus.cycle_enable);
        else n_pass++;
        send_row(0);
        drain("done_restart");
        abort_cleanup();
    endtask

    initial begin
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < RPL; r++) begin
                shf[l][r]      = '0;
                exp_rows[l][r] = '0;
            end
        test_reset();
        test_single_row();
        test_ignored_inputs();
        test_abort();
        test_full_load();
        test_done();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at 400000 ns, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kds_loader.md
# kds_loader

Sequencer that fills the kernel data shifter. It accepts kernel words one per beat over a valid/ready stream and packs each group of three words into a kernel row. It then commits each row to one of the 12 lane FIFO triples by driving `v_1..v_3`, a one-hot `LE_select` and a low `cycle_enable`. After the last row it hands the shifter over to the datapath, which rotates the kernels through `advance_in`.

## Interface
**Parameters**
- `IO_DATA_WIDTH`, 16: word width.
- `NB_LANES`, 12: lanes in the shifter; sets the `LE_select` width.
- `ROWS_PER_LANE`, 8: rows per lane; equals the shifter FIFO depth.

**Ports**
- `clk`, input, 1: single clock.
- `arst_in`, input, 1: asynchronous, active-high reset.
- `start_in`, input, 1: one-cycle pulse; begins a load.
- `abort_in`, input, 1: synchronous abort; returns to IDLE.
- `din`, input, `IO_DATA_WIDTH`: kernel word.
- `din_valid`, input, 1: `din` holds a word.
- `din_ready`, output, 1: loader accepts `din` this cycle.
- `advance_in`, input, 1: datapath request to rotate all lanes by one; honoured only in DONE.
- `v_1`, `v_2`, `v_3`, output, `IO_DATA_WIDTH` each: row words to the shifter.
- `LE_select`, output, `NB_LANES`: one-hot lane load enable.
- `cycle_enable`, output, 1: 0 means the shifter advances this cycle; 1 means it holds.
- `done`, output, 1: all `NB_LANES*ROWS_PER_LANE` rows are committed.

## Operation
**States** (`kds_state_e`): IDLE, COLLECT, COMMIT, DONE.
- **IDLE:**
  - `start_in` moves to COLLECT.
  - All counters clear.
- **COLLECT:**
  - `din_ready`=1.
  - A beat is `din_valid && din_ready`.
  - The word counter `wc` (0..2) steers the word: `wc`=0 → `v_1`, 1 → `v_2`, 2 → `v_3`.
  - The beat with `wc`=2 moves to COMMIT.
- **COMMIT:**
  - Lasts exactly one cycle; `din_ready`=0.
  - `LE_select` = one-hot(`lane`); `cycle_enable`=0.
  - `row` increments; on wrap from `ROWS_PER_LANE-1` to 0, `lane` increments.
  - After the commit with `lane`=`NB_LANES-1` and `row`=`ROWS_PER_LANE-1`, go to DONE; otherwise go to COLLECT.
- **DONE:**
  - `done`=1; `LE_select`=0; `cycle_enable`=`!advance_in`, registered.
  - `start_in` reloads: clears counters and goes to COLLECT.
- **Ordering:**
  - Non-selected lanes rotate on every commit. Lane *l* receives `(NB_LANES-l)*ROWS_PER_LANE` shifts in total, a multiple of the depth, so every lane ends with its rows in write order.
- **Priority:**
  - `abort_in` beats `start_in` and beats any handshake in the same cycle.
  - `abort_in` in any state: next cycle IDLE, counters 0, outputs at reset values. A word accepted in that cycle is discarded.
  - `start_in` outside IDLE/DONE is ignored.
  - `advance_in` outside DONE is ignored.
- **Counters:**
  - `wc` is 2 bits.
  - `row` is `$clog2(ROWS_PER_LANE)` bits.
  - `lane` is `$clog2(NB_LANES)` bits.
  - No counter reaches an out-of-range value.

## Timing
- **Registers:**
  - All outputs are registered.
  - `din_ready` is decoded from the state register.
- **Reset values:**
  - State IDLE.
  - `v_1`/`v_2`/`v_3`=0, `LE_select`=0, `cycle_enable`=1, `din_ready`=0, `done`=0.
- **Start and commit latency:**
  - `start_in` at cycle t gives `din_ready`=1 at t+1.
  - A third beat at cycle t gives COMMIT outputs at t+1 and `din_ready`=1 again at t+2.
- **Throughput:** at best 4 cycles per row, a full load takes at least `4*NB_LANES*ROWS_PER_LANE` = 384 cycles after start.
- **Data stability:**
  - `v_*` change only on their accepted beat.
  - `v_*` are stable through COMMIT.
- **`done` timing:** `done` rises in the cycle after the last COMMIT and stays high until `start_in`, `abort_in` or reset.
- **Reset mid-operation:** asynchronous `arst_in` forces reset values immediately; a partial row is lost.

## Structure
- **`kds_pkg`:** holds `kds_state_e` and the constants `KDS_NB_LANES`=12, `KDS_ROW_WORDS`=3 and `KDS_ROWS_PER_LANE`=8. The shifter uses the same package.
- **Sub-module `kds_row_assembler`:**
  - Holds the three word registers and `wc`.
  - Inputs: `din`, `beat` and `clear`.
  - Outputs: `v_1..v_3` and a `last_word` flag.
  - The top level keeps the FSM plus the `row` and `lane` counters.

## Test plan
- **Reset:** assert `arst_in` mid-cycle → all outputs at reset values at once; `din_ready`=0 until `start_in`.
- **Single row:**
  - Stimulus: start, then words 0x0011, 0x0022, 0x0033 back to back.
  - Required: next cycle `v_1..v_3` = 0x0011/0x0022/0x0033, `LE_select`=12'h001, `cycle_enable`=0 for one cycle; `din_ready` low that cycle.
- **Full load:**
  - Stimulus: 288 words with random `din_valid` gaps.
  - Required: 96 commits; `LE_select` = 12'h001 for commits 0–7, …, 12'h800 for commits 88–95; `done`=1 the cycle after commit 95.
  - Required: a shifter model holds every lane's rows in write order.
- **Abort:**
  - Stimulus: `abort_in` together with the 2nd word of lane 5, row 3.
  - Required: IDLE next cycle, `LE_select`=0, no commit; a restart loads from lane 0, row 0.
- **DONE behaviour:**
  - Stimulus: `advance_in` pattern 1,0,1 in DONE.
  - Required: `cycle_enable` = 0,1,0 one cycle later; `start_in` in DONE restarts the load with `done`=0 next cycle.
- **Ignored inputs:** `start_in` and `advance_in` during COLLECT → no state change, no extra commit.
